perf_sampler: RTL and testbench

Synthesizable per-core performance sampler; successor to the DPI-only profiler hook. It owns the counters, taking raw per-warp event strobes instead of pre-counted values. It snapshots all counters periodically and on kernel finish, then streams each snapshot out as a valid/ready word sequence to a trace sink or MMIO drain. One instance sits beside each core's issue stage, tagged by cluster/core ID.

---
 rtl/perf_sampler_pkg.sv | 19 +
 rtl/perf_sat_counter.sv | 39 +++
 rtl/perf_sampler.sv | 226 ++++++++++++++++++++++
 tb/tb_perf_sampler.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/perf_sampler_pkg.sv
// Shared types and record layout for the per-core performance sampler.
package perf_sampler_pkg;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        DRAIN_FINAL,
        DONE
    } state_t;

    localparam int BEAT_CYCLES   = 0;
    localparam int BEAT_INSTRET  = 1;
    localparam int BEAT_EVT_BASE = 2;

    function automatic int beat_count(input int num_warps, input int num_events);
        return BEAT_EVT_BASE + num_warps * num_events;
    endfunction

endpackage

// File: rtl/perf_sat_counter.sv
// Saturating up-counter with variable increment; sticks at all-ones.
// Latency: next_o is combinational next-state; no backpressure.
// Backpressure: none.
module perf_sat_counter #(
    parameter int WIDTH = 64,
    parameter int INC_W = 1
) (
    input  logic             clock,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic [INC_W-1:0] inc_i,
    output logic [WIDTH-1:0] next_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH:0]   sum;

    assign sum = {1'b0, count_q} + (WIDTH + 1)'(inc_i);

    always_comb begin
        count_d = count_q;
        if (en_i) begin
            count_d = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
        end
    end

    // Exposing the next state lets a snapshot include this cycle's increment.
    assign next_o = count_d;

    always_ff @(posedge clock) begin
        if (clear_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/perf_sampler.sv
// Per-core perf counters, snapshotted periodically and on finish, streamed as records.
// Latency: out_valid one cycle after snapshot; one beat per cycle with out_ready high.
// Backpressure: beats hold under !out_ready; periodic samples arriving mid-record are dropped and counted.
module perf_sampler
    import perf_sampler_pkg::*;
#(
    parameter int NUM_WARPS     = 8,
    parameter int NUM_EVENTS    = 5,
    parameter int COUNTER_WIDTH = 64,
    parameter int RET_W         = 4,
    parameter int INTERVAL_W    = 32,
    parameter int CLUSTER_ID    = 0,
    parameter int CORE_ID       = 0
) (
    input  logic                                          clock,
    input  logic                                          reset,
    input  logic                                          en,
    input  logic [INTERVAL_W-1:0]                         interval,
    input  logic [NUM_WARPS*NUM_EVENTS-1:0]               evt,
    input  logic [RET_W-1:0]                              retired,
    input  logic                                          finished,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [COUNTER_WIDTH-1:0]                      out_data,
    output logic [$clog2(2+NUM_WARPS*NUM_EVENTS)-1:0]     out_idx,
    output logic [15:0]                                   out_src,
    output logic                                          out_last,
    output logic                                          out_final,
    output logic [15:0]                                   dropped,
    output logic                                          done
);

    localparam int NUM_CNT   = NUM_WARPS * NUM_EVENTS;
    localparam int NUM_BEATS = beat_count(NUM_WARPS, NUM_EVENTS);
    localparam int IDX_W     = $clog2(NUM_BEATS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BEATS - 1);

    state_t                  state_q;
    logic                    out_valid_q;
    logic                    out_last_q;
    logic                    out_final_q;
    logic                    done_q;
    logic                    pend_q;
    logic                    finished_q;
    logic [IDX_W-1:0]        idx_q;
    logic [15:0]             dropped_q;
    logic [INTERVAL_W-1:0]   timer_q;

    logic [COUNTER_WIDTH-1:0] live_d   [NUM_BEATS];
    logic [COUNTER_WIDTH-1:0] shadow_q [NUM_BEATS];

    logic frozen;
    logic cnt_en;
    logic fin_edge;
    logic final_req;
    logic periodic;
    logic beat_hs;
    logic last_hs;
    logic snap;
    logic snap_final;
    logic drop_evt;

    assign frozen    = (state_q == DRAIN_FINAL) || (state_q == DONE);
    assign cnt_en    = en && !frozen;
    assign fin_edge  = finished && !finished_q;
    assign final_req = fin_edge || pend_q;
    assign periodic  = cnt_en && (interval != '0) && (timer_q == interval - INTERVAL_W'(1));
    assign beat_hs   = out_valid_q && out_ready;
    assign last_hs   = beat_hs && (idx_q == LAST_IDX);

    always_comb begin
        snap       = 1'b0;
        snap_final = 1'b0;
        case (state_q)
            RUN: begin
                if (fin_edge) begin
                    snap       = 1'b1;
                    snap_final = 1'b1;
                end else if (periodic) begin
                    snap = 1'b1;
                end
            end
            DRAIN: begin
                if (last_hs && final_req) begin
                    snap       = 1'b1;
                    snap_final = 1'b1;
                end
            end
            default: begin
                snap       = 1'b0;
                snap_final = 1'b0;
            end
        endcase
    end

    // A periodic trigger absorbed by a same-cycle final snapshot is not a drop.
    assign drop_evt = periodic && (state_q == DRAIN) && !snap;

    always_ff @(posedge clock) begin
        if (reset) begin
            timer_q <= '0;
        end else if (cnt_en) begin
            if (periodic || ((interval != '0) && (timer_q >= interval))) begin
                timer_q <= '0;
            end else begin
                timer_q <= timer_q + INTERVAL_W'(1);
            end
        end
    end

    perf_sat_counter #(.WIDTH(COUNTER_WIDTH), .INC_W(1)) u_cycles (
        .clock   (clock),
        .clear_i (reset),
        .en_i    (cnt_en),
        .inc_i   (1'b1),
        .next_o  (live_d[BEAT_CYCLES])
    );

    perf_sat_counter #(.WIDTH(COUNTER_WIDTH), .INC_W(RET_W)) u_instret (
        .clock   (clock),
        .clear_i (reset),
        .en_i    (cnt_en),
        .inc_i   (retired),
        .next_o  (live_d[BEAT_INSTRET])
    );

    for (genvar k = 0; k < NUM_CNT; k++) begin : g_evt
        perf_sat_counter #(.WIDTH(COUNTER_WIDTH), .INC_W(1)) u_evt (
            .clock   (clock),
            .clear_i (reset),
            .en_i    (cnt_en),
            .inc_i   (evt[k]),
            .next_o  (live_d[BEAT_EVT_BASE+k])
        );
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_BEATS; i++) begin
                shadow_q[i] <= '0;
            end
        end else if (snap) begin
            for (int i = 0; i < NUM_BEATS; i++) begin
                shadow_q[i] <= live_d[i];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= RUN;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_final_q <= 1'b0;
            done_q      <= 1'b0;
            pend_q      <= 1'b0;
            finished_q  <= 1'b0;
            idx_q       <= '0;
            dropped_q   <= '0;
        end else begin
            finished_q <= finished;
            if (drop_evt && (dropped_q != '1)) begin
                dropped_q <= dropped_q + 16'd1;
            end
            case (state_q)
                RUN: begin
                    if (snap) begin
                        out_valid_q <= 1'b1;
                        idx_q       <= '0;
                        out_last_q  <= 1'b0;
                        out_final_q <= snap_final;
                        state_q     <= snap_final ? DRAIN_FINAL : DRAIN;
                    end
                end
                DRAIN: begin
                    if (fin_edge) begin
                        pend_q <= 1'b1;
                    end
                    if (last_hs) begin
                        idx_q      <= '0;
                        out_last_q <= 1'b0;
                        if (snap) begin
                            out_final_q <= 1'b1;
                            pend_q      <= 1'b0;
                            state_q     <= DRAIN_FINAL;
                        end else begin
                            out_valid_q <= 1'b0;
                            state_q     <= RUN;
                        end
                    end else if (beat_hs) begin
                        idx_q      <= idx_q + IDX_W'(1);
                        out_last_q <= ((idx_q + IDX_W'(1)) == LAST_IDX);
                    end
                end
                DRAIN_FINAL: begin
                    if (last_hs) begin
                        idx_q       <= '0;
                        out_last_q  <= 1'b0;
                        out_valid_q <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= DONE;
                    end else if (beat_hs) begin
                        idx_q      <= idx_q + IDX_W'(1);
                        out_last_q <= ((idx_q + IDX_W'(1)) == LAST_IDX);
                    end
                end
                DONE: begin
                    state_q <= DONE;
                end
                default: begin
                    state_q <= RUN;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = shadow_q[idx_q];
    assign out_idx   = idx_q;
    assign out_src   = {8'(CLUSTER_ID), 8'(CORE_ID)};
    assign out_last  = out_last_q;
    assign out_final = out_final_q;
    assign dropped   = dropped_q;
    assign done      = done_q;

endmodule

// File: tb/tb_perf_sampler.sv
// Randomized bench for perf_sampler: a record-level model pushes expected beats, a monitor pops on handshake.
module tb_perf_sampler;

    localparam int NW  = 2;
    localparam int NE  = 2;
    localparam int NC  = NW * NE;
    localparam int NB  = 2 + NC;
    localparam int CW  = 8;
    localparam int RW  = 4;
    localparam int IW  = 32;
    localparam int unsigned CMAX = 255;
    localparam logic [15:0] SRC = 16'h0305;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          en = 1'b0;
    logic [IW-1:0] interval = '0;
    logic [NC-1:0] evt = '0;
    logic [RW-1:0] retired = '0;
    logic          finished = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [CW-1:0] out_data;
    logic [2:0]    out_idx;
    logic [15:0]   out_src;
    logic          out_last;
    logic          out_final;
    logic [15:0]   dropped;
    logic          done;

    perf_sampler #(
        .NUM_WARPS(NW), .NUM_EVENTS(NE), .COUNTER_WIDTH(CW), .RET_W(RW),
        .INTERVAL_W(IW), .CLUSTER_ID(3), .CORE_ID(5)
    ) dut (
        .clock(clock), .reset(reset), .en(en), .interval(interval), .evt(evt),
        .retired(retired), .finished(finished), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
        .out_src(out_src), .out_last(out_last), .out_final(out_final),
        .dropped(dropped), .done(done)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [15:0]   src;
        logic          fin;
        logic          last;
        logic [2:0]    idx;
        logic [CW-1:0] data;
    } beat_t;

    beat_t exp_q[$];
    beat_t mon_e;
    int n_cmp = 0;
    int n_bad = 0;
    bit mon_on = 1'b0;

    // Reference model: counters as plain integers, record-in-flight as a beat count.
    int unsigned m_cnt [NB];
    int unsigned m_timer;
    int unsigned m_drop;
    int          m_beat;
    bit m_busy, m_frec, m_frozen, m_pend, m_done, m_finp;
    bit vis_valid, vis_done;
    int unsigned vis_drop;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int unsigned sat(input int unsigned a, input int unsigned b);
        return (a + b > CMAX) ? CMAX : a + b;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NB; i++) m_cnt[i] = 0;
        m_timer = 0; m_drop = 0; m_beat = 0;
        m_busy = 0; m_frec = 0; m_frozen = 0; m_pend = 0; m_done = 0; m_finp = 0;
        vis_valid = 0; vis_done = 0; vis_drop = 0;
    endfunction

    function automatic void push_record(input bit fin);
        beat_t b;
        for (int i = 0; i < NB; i++) begin
            b.src  = SRC;
            b.fin  = fin;
            b.last = (i == NB - 1);
            b.idx  = 3'(i);
            b.data = CW'(m_cnt[i]);
            exp_q.push_back(b);
        end
    endfunction

    // Advances the model across the coming clock edge using the inputs just applied.
    function automatic void model_step();
        bit fe, en_e, per, hs, lst;
        vis_valid = m_busy;
        vis_drop  = m_drop;
        vis_done  = m_done;
        fe     = finished && !m_finp;
        m_finp = finished;
        en_e   = en && !m_frozen;
        per    = en_e && (interval != 0) && (m_timer == interval - 1);
        if (en_e) begin
            if (per || ((interval != 0) && (m_timer >= interval))) m_timer = 0;
            else m_timer = m_timer + 1;
            m_cnt[0] = sat(m_cnt[0], 1);
            m_cnt[1] = sat(m_cnt[1], retired);
            for (int k = 0; k < NC; k++) m_cnt[2+k] = sat(m_cnt[2+k], evt[k]);
        end
        hs  = m_busy && out_ready;
        lst = hs && (m_beat == NB - 1);
        if (!m_busy) begin
            if (!m_frozen) begin
                if (fe) begin
                    push_record(1'b1);
                    m_busy = 1; m_beat = 0; m_frec = 1; m_frozen = 1;
                end else if (per) begin
                    push_record(1'b0);
                    m_busy = 1; m_beat = 0; m_frec = 0;
                end
            end
        end else begin
            if (fe && !m_frec) m_pend = 1;
            if (per && !(lst && m_pend) && m_drop < 65535) m_drop = m_drop + 1;
            if (hs) begin
                if (!lst) m_beat = m_beat + 1;
                else if (m_frec) begin m_busy = 0; m_done = 1; end
                else if (m_pend) begin
                    push_record(1'b1);
                    m_beat = 0; m_frec = 1; m_frozen = 1; m_pend = 0;
                end else m_busy = 0;
            end
        end
    endfunction

    task automatic drive(input logic en_v, input logic [IW-1:0] iv, input logic [NC-1:0] ev,
                         input logic [RW-1:0] rt, input logic fin, input logic rdy);
        @(posedge clock); #1;
        reset = 1'b0; en = en_v; interval = iv; evt = ev; retired = rt;
        finished = fin; out_ready = rdy;
        model_step();
    endtask

    task automatic do_reset();
        @(posedge clock); #1;
        reset = 1'b1; en = 0; interval = '0; evt = '0; retired = '0; finished = 0; out_ready = 0;
        @(posedge clock); #1;
        model_reset();
        exp_q.delete();
        @(negedge clock);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_idx",   64'(out_idx),   64'd0);
        check("rst_out_last",  64'(out_last),  64'd0);
        check("rst_out_final", 64'(out_final), 64'd0);
        check("rst_dropped",   64'(dropped),   64'd0);
        check("rst_done",      64'(done),      64'd0);
    endtask

    always @(negedge clock) begin
        if (mon_on && !reset) begin
            check("out_valid", 64'(out_valid), 64'(vis_valid));
            check("dropped",   64'(dropped),   64'(vis_drop));
            check("done",      64'(done),      64'(vis_done));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_beat: got idx %0d data %0h, expected no beat at %0t",
                             out_idx, out_data, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("beat", 64'({out_src, out_final, out_last, out_idx, out_data}), 64'(mon_e));
                end
            end
        end
    end

    initial begin
        logic fin_r;
        logic [IW-1:0] iv_r;
        int fin_at;
        model_reset();
        do_reset();
        mon_on = 1'b1;

        // Basic periodic record: interval 10, evt bit0 held, one retire per cycle.
        repeat (20) drive(1, 10, 4'b0001, 1, 0, 1);

        // Sink stalled across several triggers, then released.
        do_reset();
        repeat (40) drive(1, 10, 4'b0001, 1, 0, 0);
        repeat (20) drive(1, 10, 4'b0001, 1, 0, 1);

        // Finish raised while a periodic record drains.
        do_reset();
        repeat (12) drive(1, 10, 4'b0101, 2, 0, 1);
        for (int i = 0; i < 60 && !m_done; i++) drive(1, 10, NC'($urandom), RW'($urandom), 1, 1);
        check("final_done_model", 64'(m_done), 64'd1);
        repeat (25) drive(1, 10, NC'($urandom), RW'($urandom), 1, 1);

        // Instret saturation at the counter width.
        do_reset();
        repeat (20) drive(1, 21, 4'b1111, 15, 0, 1);
        repeat (10) drive(1, 21, 4'b0000, 0, 0, 1);

        // Periodic sampling disabled; only the final record appears.
        do_reset();
        repeat (49) drive(1, 0, NC'($urandom), RW'($urandom), 0, 1);
        repeat (20) drive(1, 0, NC'($urandom), RW'($urandom), 1, 1);

        // Reset in the middle of a record.
        do_reset();
        for (int i = 0; i < 40 && !(m_busy && m_beat == 3); i++) drive(1, 10, 4'b0011, 3, 0, 1);
        check("reach_beat3_model", 64'(m_busy && m_beat == 3), 64'd1);
        do_reset();
        repeat (25) drive(1, 10, 4'b0010, 1, 0, 1);

        // Random segments with varying sink readiness and finish toggling.
        for (int seg = 0; seg < 6; seg++) begin
            do_reset();
            iv_r   = IW'($urandom_range(0, 12));
            fin_r  = 1'b0;
            fin_at = $urandom_range(80, 500);
            for (int c = 0; c < 450; c++) begin
                if ($urandom_range(0, 40) == 0) iv_r = IW'($urandom_range(0, 12));
                if (c >= fin_at && $urandom_range(0, 20) == 0) fin_r = ~fin_r;
                drive(($urandom_range(0, 3) != 0), iv_r, NC'($urandom), RW'($urandom), fin_r,
                      (seg % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0));
            end
            repeat (NB + 4) drive(0, 0, '0, '0, fin_r, 1);
            check("queue_drained", 64'(exp_q.size()), 64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
